// File: rtl/dm_lsu.sv
// Load/store unit: turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-wide dm accesses.
// Define DM_LSU_RMW_EN to build read-modify-write sub-word stores; otherwise sb/sh complete as errors.
module dm_lsu #(
  parameter int unsigned DM_AW = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             sext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      ld_data,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_rd,
  output logic             dm_wr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

`ifdef DM_LSU_RMW_EN
  typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_DONE} state_e;
`endif

  state_e             state_q;
  logic               busy_q, done_q, err_q, dm_rd_q, dm_wr_q;
  logic [31:0]        ld_data_q, dm_wdata_q;
  logic [DM_AW-1:0]   dm_addr_q;
  logic [1:0]         addr_lo_q, size_q;
  logic               sext_q;
  logic               acc_err_c;
  logic [31:0]        ld_ext_c;
  logic [7:0]         lane_b_c;
  logic [15:0]        lane_h_c;
`ifdef DM_LSU_RMW_EN
  logic [15:0]        wdata_q;
  logic [31:0]        merge_c;
`endif

  // Request legality: illegal size, misalignment, or beyond the dm window.
  always_comb begin
    acc_err_c = (size == 2'b11)
             || (size == 2'b01 && addr[0])
             || (size == 2'b10 && addr[1:0] != 2'b00)
             || ((addr >> (DM_AW + 2)) != 32'd0);
`ifndef DM_LSU_RMW_EN
    if (we && size != 2'b10) acc_err_c = 1'b1;
`endif
  end

  // Lane select and extension of the word returned in LD.
  always_comb begin
    lane_b_c = dm_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h_c = addr_lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext_c = {{24{sext_q & lane_b_c[7]}}, lane_b_c};
      2'b01:   ld_ext_c = {{16{sext_q & lane_h_c[15]}}, lane_h_c};
      default: ld_ext_c = dm_rdata;
    endcase
  end

`ifdef DM_LSU_RMW_EN
  // The word read in RMW_RD with the store lane replaced, ready for RMW_WR.
  always_comb begin
    merge_c = dm_rdata;
    if (size_q == 2'b00) merge_c[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merge_c[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      dm_wdata_q <= 32'd0;
      dm_addr_q  <= '0;
      ld_data_q  <= 32'd0;
      addr_lo_q  <= 2'b00;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
`ifdef DM_LSU_RMW_EN
      wdata_q    <= 16'd0;
`endif
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      dm_wdata_q <= 32'd0;
      case (state_q)
        S_IDLE: if (req) begin
          addr_lo_q <= addr[1:0];
          size_q    <= size;
          sext_q    <= sext;
`ifdef DM_LSU_RMW_EN
          wdata_q   <= wdata[15:0];
`endif
          dm_addr_q <= addr[DM_AW+1:2];
          busy_q    <= 1'b1;
          if (acc_err_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (!we) begin
            state_q <= S_LD;
            dm_rd_q <= 1'b1;
`ifdef DM_LSU_RMW_EN
          end else if (size != 2'b10) begin
            state_q <= S_RMW_RD;
            dm_rd_q <= 1'b1;
`endif
          end else begin
            state_q    <= S_ST;
            dm_wr_q    <= 1'b1;
            dm_wdata_q <= wdata;
          end
        end
        S_LD: begin
          ld_data_q <= ld_ext_c;
          state_q   <= S_DONE;
          done_q    <= 1'b1;
        end
        S_ST: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
`ifdef DM_LSU_RMW_EN
        S_RMW_RD: begin
          state_q    <= S_RMW_WR;
          dm_wr_q    <= 1'b1;
          dm_wdata_q <= merge_c;
        end
        S_RMW_WR: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
`endif
        S_DONE: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          dm_addr_q <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          dm_addr_q <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ld_data  = ld_data_q;
  assign dm_addr  = dm_addr_q;
  assign dm_rd    = dm_rd_q;
  // A write still pending when reset arrives must not reach memory.
  assign dm_wr    = dm_wr_q & rst_n;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: directed cases plus random traffic against a word-array memory model.
module tb_dm_lsu;
  localparam int unsigned DM_AW = 7;
  localparam int unsigned NW    = 1 << DM_AW;
`ifdef DM_LSU_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic             clk, rst_n, req, we, sext;
  logic [1:0]       size;
  logic [31:0]      addr, wdata;
  logic             busy, done, err, dm_rd, dm_wr;
  logic [31:0]      ld_data, dm_wdata, dm_rdata;
  logic [DM_AW-1:0] dm_addr;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic        clr;
  logic [31:0] ld_exp;
  int          n_tests, n_fail;

  dm_lsu #(.DM_AW(DM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .ld_data(ld_data), .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: combinational read, write on the clock edge.
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(NW); i++) mem[i] <= 32'd0;
    end else if (dm_wr) begin
      mem[dm_addr] <= dm_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (a >= 32'(4 * NW)) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    if (w && sz != 2'b10 && !RMW) return 1'b1;
    return 1'b0;
  endfunction

  task automatic junk_req();
    req   = 1'($urandom_range(0, 1));
    we    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    bit          e;
    int          lat, rd_cyc, wr_cyc, widx, sh;
    logic [31:0] old, newv, mask, v;
    e      = model_err(w, sz, a);
    widx   = int'((a / 4) % NW);
    sh     = 8 * int'(a % 4);
    old    = ref_mem[widx];
    newv   = old;
    rd_cyc = 0;
    wr_cyc = 0;
    if (e) begin
      lat = 1;
    end else if (!w) begin
      lat = 2; rd_cyc = 1;
      v = old >> sh;
      if (sz == 2'b00) begin
        v = v & 32'h0000_00FF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = v & 32'h0000_FFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
      ld_exp = v;
    end else if (sz == 2'b10) begin
      lat = 2; wr_cyc = 1; newv = d;
    end else begin
      lat = 3; rd_cyc = 1; wr_cyc = 2;
      mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      newv = (old & ~mask) | ((d << sh) & mask);
    end
    issue(w, sz, sx, a, d);
    for (int k = 1; k <= lat; k++) begin
      junk_req();
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == lat));
      check("err", 32'(err), 32'((k == lat) && e));
      check("dm_rd", 32'(dm_rd), 32'(k == rd_cyc));
      check("dm_wr", 32'(dm_wr), 32'(k == wr_cyc));
      if (k == rd_cyc || k == wr_cyc) check("dm_addr", 32'(dm_addr), 32'(widx));
      check("dm_wdata", dm_wdata, (k == wr_cyc) ? newv : 32'd0);
      if (k == lat) check("ld_data", ld_data, ld_exp);
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    ref_mem[widx] = newv;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_addr", 32'(dm_addr), 32'd0);
    check("mem", mem[widx], newv);
  endtask

  // Store whose write cycle coincides with reset: no write, everything cleared.
  task automatic reset_abort(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int wr_cyc, widx;
    widx   = int'((a / 4) % NW);
    wr_cyc = (sz == 2'b10) ? 1 : 2;
    issue(1'b1, sz, 1'b0, a, d);
    req = 1'b0;
    for (int k = 1; k < wr_cyc; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_dm_rd", 32'(dm_rd), 32'd0);
    check("rst_dm_wr2", 32'(dm_wr), 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    rst_n  = 1'b1;
    ld_exp = 32'd0;
    @(posedge clk);
    #1;
    check("rst_mem", mem[widx], ref_mem[widx]);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    n_tests = 0; n_fail = 0; ld_exp = 32'd0;
    rst_n = 1'b0; clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ld_data", ld_data, 32'd0);
    check("reset_dm_rd", 32'(dm_rd), 32'd0);
    check("reset_dm_wr", 32'(dm_wr), 32'd0);
    check("reset_dm_addr", 32'(dm_addr), 32'd0);
    clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344);
    do_op(1'b0, 2'b00, 1'b0, 32'h013, 32'd0);
    do_op(1'b1, 2'b00, 1'b0, 32'h011, 32'h0000_00AB);
    do_op(1'b0, 2'b10, 1'b0, 32'h010, 32'd0);
    do_op(1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF_0000);
    do_op(1'b0, 2'b01, 1'b1, 32'h022, 32'd0);
    do_op(1'b0, 2'b01, 1'b0, 32'h022, 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h006, 32'd0);
    do_op(1'b0, 2'b01, 1'b0, 32'h003, 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
    do_op(1'b0, 2'b11, 1'b0, 32'h010, 32'd0);
`ifdef DM_LSU_RMW_EN
    reset_abort(2'b01, 32'h010, 32'h0000_5A5A);
`else
    reset_abort(2'b10, 32'h010, 32'hDEAD_BEEF);
`endif
    do_op(1'b0, 2'b10, 1'b0, 32'h010, 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h1FC, 32'd0);

    for (int n = 0; n < 400; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'b01) ra = ra & ~32'd1;
        if (rs == 2'b10) ra = ra & ~32'd3;
      end
      do_op(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
